l1_l2_arbiter: RTL and testbench
================================

// Module: l1_l2_arbiter
// PURPOSE
//  Shares the single L1->L2 request port between the L1 instruction-cache controller (I) and the
//  L1 data-cache controller (D). Registers one grant at a time and forwards the owner's read/write,
//  tag, index and write-back block to L2. Routes L2's ready pulse back to the owner only.
//  Sits between both L1 controllers and the L2 controller.
// PARAMETERS
//  TNUM_2   18    L2 tag bits
//  INUM_2   8     L2 index bits (26 - TNUM_2)
//  BLK_W    512   cache block width in bits (write-back data)
//  TIMEOUT  255   watchdog limit in cycles; used only with L1_L2_ARB_TIMEOUT_EN
// PORTS
//  clk            in   1        clock, rising edge
//  nrst           in   1        reset: synchronous, active-high (nrst=1 -> reset)
//  read_I_L2      in   1        I-side miss read request, level, held until ready_L2_I
//  tag_I_L2       in   TNUM_2   I-side tag
//  index_I_L2     in   INUM_2   I-side index
//  read_D_L2      in   1        D-side read request, level
//  write_D_L2     in   1        D-side write-back request, level (read and write are mutually exclusive)
//  tag_D_L2       in   TNUM_2   D-side tag
//  index_D_L2     in   INUM_2   D-side index
//  wdata_D_L2     in   BLK_W    D-side write-back block
//  ready_L2_L1    in   1        L2 completion pulse for the current transaction
//  ready_L2_I     out  1        completion pulse to I
//  ready_L2_D     out  1        completion pulse to D
//  read_L1_L2     out  1        read request to L2
//  write_L1_L2    out  1        write request to L2
//  tag_L1_L2      out  TNUM_2   tag to L2
//  index_L1_L2    out  INUM_2   index to L2
//  wdata_L1_L2    out  BLK_W    write-back block to L2
//  owner          out  1        0 = I, 1 = D; valid while read/write_L1_L2 is asserted
//  arb_err        out  1        timeout pulse (tied 0 without L1_L2_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=I (I has priority on first contention), all outputs 0.
//  - FSM states: IDLE, GNT_I, GNT_D, RELEASE.
//  - IDLE:
//    - Only reqI=read_I_L2 -> GNT_I; only reqD=(read_D_L2|write_D_L2) -> GNT_D.
//    - Both asserted -> grant the side named by rr_ptr.
//    - Neither asserted -> stay in IDLE.
//    - The grant takes effect the cycle after the request is sampled (1-cycle latency).
//  - On entering GNT_x: capture the owner's request type, tag, index and wdata into registers.
//    Outputs to L2 are driven from those registers and stay stable for the whole grant, even if
//    the requester changes its inputs.
//  - GNT_x: read/write_L1_L2 held high. When ready_L2_L1=1:
//    - ready_L2_x = ready_L2_L1 (same cycle, combinational).
//    - The other side's ready stays 0.
//    - L2 request drops next cycle.
//    - rr_ptr := the other side; state -> RELEASE.
//  - RELEASE: exactly 1 cycle, no grant and no L2 request. This absorbs the requester's stale
//    request level. Then -> IDLE.
//  - Requester deasserts mid-grant: the grant is held until ready_L2_L1. L2 transactions cannot be
//    cancelled. The ready pulse is still delivered.
//  - ready_L2_L1 in IDLE/RELEASE: ignored, no ready_L2_I/D pulse.
//  - Back-to-back contention alternates I, D, I, D. Minimum grant-to-grant spacing is 3 cycles
//    (GNT, RELEASE, IDLE).
//  - nrst high in any state: return to IDLE next edge, request outputs 0, in-flight grant dropped.
// CONFIGURATION
//  L1_L2_ARB_TIMEOUT_EN defined:
//    - An 8-bit+ counter clears on grant entry and increments each GNT_x cycle.
//    - At TIMEOUT cycles with no ready_L2_L1: arb_err pulses 1 cycle, request dropped, no ready
//      to owner, -> RELEASE, rr_ptr flips.
//  Undefined: no counter, arb_err tied 0, grant held indefinitely.
// STRUCTURE
//  Package l1_l2_arb_pkg: typedef enum arb_state_t {IDLE,GNT_I,GNT_D,RELEASE};
//    typedef enum logic owner_t {OWN_I=0,OWN_D=1}; default TNUM_2/INUM_2/BLK_W localparams.
//  Sub-module arb_rr_pick2: combinational 2-way round-robin picker
//    (reqI, reqD, rr_ptr -> gnt_valid, gnt_owner).
// TESTING
//  1 I alone: read_I_L2=1, tag=18'h0ABCD, index=8'h3C
//    -> next cycle read_L1_L2=1, owner=0, tag/index match.
//    ready_L2_L1 pulse -> ready_L2_I=1 same cycle, read_L1_L2=0 next cycle.
//  2 D write-back: write_D_L2=1, wdata=512'hA5..A5
//    -> write_L1_L2=1, owner=1, wdata_L1_L2 matches.
//    ready pulse -> ready_L2_D only; ready_L2_I stays 0.
//  3 Contention after reset: both request same cycle -> I granted first.
//    After its ready + RELEASE, D granted. Repeat both -> order I, D, I, D.
//  4 Stability: change tag_I_L2 mid-grant -> tag_L1_L2 unchanged.
//    Drop read_I_L2 mid-grant -> grant holds, ready_L2_I still pulses.
//  5 Stray ready: pulse ready_L2_L1 in IDLE -> no ready_L2_I/D.
//    nrst=1 during GNT_D -> next cycle IDLE, all outputs 0.
//  6 L1_L2_ARB_TIMEOUT_EN, TIMEOUT=16: grant I, withhold ready
//    -> arb_err pulses at cycle 16 of grant, read_L1_L2 drops, no ready_L2_I.

Source files
------------

// File: rtl/l1_l2_arbiter_pkg.sv
// l1_l2_arb_pkg: shared types and default widths for the L1->L2 request-port arbiter.
package l1_l2_arb_pkg;

  localparam int DEF_TNUM_2 = 18;
  localparam int DEF_INUM_2 = 26 - DEF_TNUM_2;
  localparam int DEF_BLK_W  = 512;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I   = 2'd1,
    GNT_D   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // The side that gets priority next after the given side finishes.
  function automatic owner_t other_side(input owner_t side);
    return (side == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/l1_l2_arbiter_if.sv
// l1_l2_arbiter_if: bundles both L1 request ports and the shared L2 port.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface l1_l2_arbiter_if
  import l1_l2_arb_pkg::*;
#(
  parameter int TNUM_2 = DEF_TNUM_2,
  parameter int INUM_2 = DEF_INUM_2,
  parameter int BLK_W  = DEF_BLK_W
);

  // I-side request
  logic              read_I_L2;
  logic [TNUM_2-1:0] tag_I_L2;
  logic [INUM_2-1:0] index_I_L2;

  // D-side request
  logic              read_D_L2;
  logic              write_D_L2;
  logic [TNUM_2-1:0] tag_D_L2;
  logic [INUM_2-1:0] index_D_L2;
  logic [BLK_W-1:0]  wdata_D_L2;

  // L2 completion and routed readies
  logic              ready_L2_L1;
  logic              ready_L2_I;
  logic              ready_L2_D;

  // Forwarded request to L2
  logic              read_L1_L2;
  logic              write_L1_L2;
  logic [TNUM_2-1:0] tag_L1_L2;
  logic [INUM_2-1:0] index_L1_L2;
  logic [BLK_W-1:0]  wdata_L1_L2;
  logic              owner;
  logic              arb_err;

  modport slave (
    input  read_I_L2, tag_I_L2, index_I_L2,
    input  read_D_L2, write_D_L2, tag_D_L2, index_D_L2, wdata_D_L2,
    input  ready_L2_L1,
    output ready_L2_I, ready_L2_D,
    output read_L1_L2, write_L1_L2, tag_L1_L2, index_L1_L2, wdata_L1_L2,
    output owner, arb_err
  );

  modport master (
    output read_I_L2, tag_I_L2, index_I_L2,
    output read_D_L2, write_D_L2, tag_D_L2, index_D_L2, wdata_D_L2,
    output ready_L2_L1,
    input  ready_L2_I, ready_L2_D,
    input  read_L1_L2, write_L1_L2, tag_L1_L2, index_L1_L2, wdata_L1_L2,
    input  owner, arb_err
  );

endinterface

// File: rtl/l1_l2_arbiter_rr_pick2.sv
// arb_rr_pick2: combinational two-way round-robin picker.
// A lone requester always wins; on contention rr_ptr names the winner.
module arb_rr_pick2
  import l1_l2_arb_pkg::*;
(
  input  logic   req_icache,
  input  logic   req_dcache,
  input  owner_t rr_ptr,
  output logic   gnt_valid,
  output owner_t gnt_owner
);

  // Resolve the winner from the two request levels and the priority pointer.
  always_comb begin
    gnt_valid = req_icache | req_dcache;
    gnt_owner = OWN_I;
    if (req_icache && req_dcache) begin
      gnt_owner = rr_ptr;
    end else if (req_dcache) begin
      gnt_owner = OWN_D;
    end
  end

endmodule

// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: shares the single L1->L2 request port between the I- and D-cache
// controllers. One grant at a time; the winner's request is captured on grant entry
// and held stable toward L2 until L2 answers with ready_L2_L1.
// Optional feature macro: L1_L2_ARB_TIMEOUT_EN adds a watchdog (TIMEOUT cycles) that
// abandons a grant L2 never answers and pulses arb_err.
module l1_l2_arbiter
  import l1_l2_arb_pkg::*;
#(
  parameter int TNUM_2 = DEF_TNUM_2,
  parameter int INUM_2 = DEF_INUM_2,
  parameter int BLK_W  = DEF_BLK_W
`ifdef L1_L2_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input logic            clk,
  input logic            nrst,
  l1_l2_arbiter_if.slave bus
);

  arb_state_t state, state_next;
  owner_t     rr_ptr, rr_ptr_next;

  logic   req_icache, req_dcache;
  logic   gnt_valid;
  owner_t gnt_owner;

  logic   load_grant;
  logic   granted;
  logic   timeout_hit;
  logic   ready_to_icache, ready_to_dcache;

  logic              rd_q, wr_q;
  owner_t            owner_q;
  logic [TNUM_2-1:0] tag_q;
  logic [INUM_2-1:0] index_q;
  logic [BLK_W-1:0]  wdata_q;

  assign req_icache = bus.read_I_L2;
  assign req_dcache = bus.read_D_L2 | bus.write_D_L2;
  assign granted    = (state == GNT_I) || (state == GNT_D);

  arb_rr_pick2 u_pick (
    .req_icache (req_icache),
    .req_dcache (req_dcache),
    .rr_ptr     (rr_ptr),
    .gnt_valid  (gnt_valid),
    .gnt_owner  (gnt_owner)
  );

`ifdef L1_L2_ARB_TIMEOUT_EN
  localparam int CNT_BITS = $clog2(TIMEOUT + 1);
  localparam int CNT_W    = (CNT_BITS < 8) ? 8 : CNT_BITS;

  logic [CNT_W-1:0] wd_cnt;

  // Watchdog counts cycles spent in the current grant, restarting on every new grant.
  always_ff @(posedge clk) begin
    if (nrst) begin
      wd_cnt <= '0;
    end else if (load_grant) begin
      wd_cnt <= '0;
    end else if (granted) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  // A ready arriving on the last allowed cycle still wins over the timeout.
  assign timeout_hit = granted && !bus.ready_L2_L1 && (wd_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register and round-robin pointer; reset returns to IDLE with I favoured.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state  <= IDLE;
      rr_ptr <= OWN_I;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  // Next-state logic plus routing of L2's ready pulse to the current owner only.
  always_comb begin
    state_next      = state;
    rr_ptr_next     = rr_ptr;
    load_grant      = 1'b0;
    ready_to_icache = 1'b0;
    ready_to_dcache = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          load_grant = 1'b1;
          state_next = (gnt_owner == OWN_I) ? GNT_I : GNT_D;
        end
      end
      GNT_I: begin
        if (bus.ready_L2_L1) begin
          ready_to_icache = 1'b1;
          state_next      = RELEASE;
          rr_ptr_next     = other_side(OWN_I);
        end else if (timeout_hit) begin
          state_next  = RELEASE;
          rr_ptr_next = other_side(OWN_I);
        end
      end
      GNT_D: begin
        if (bus.ready_L2_L1) begin
          ready_to_dcache = 1'b1;
          state_next      = RELEASE;
          rr_ptr_next     = other_side(OWN_D);
        end else if (timeout_hit) begin
          state_next  = RELEASE;
          rr_ptr_next = other_side(OWN_D);
        end
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the winner's request on grant entry so L2 sees a stable request for the whole grant.
  always_ff @(posedge clk) begin
    if (nrst) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      owner_q <= OWN_I;
      tag_q   <= '0;
      index_q <= '0;
      wdata_q <= '0;
    end else if (load_grant) begin
      owner_q <= gnt_owner;
      if (gnt_owner == OWN_I) begin
        rd_q    <= 1'b1;
        wr_q    <= 1'b0;
        tag_q   <= bus.tag_I_L2;
        index_q <= bus.index_I_L2;
        wdata_q <= '0;
      end else begin
        rd_q    <= bus.read_D_L2;
        wr_q    <= bus.write_D_L2;
        tag_q   <= bus.tag_D_L2;
        index_q <= bus.index_D_L2;
        wdata_q <= bus.wdata_D_L2;
      end
    end
  end

  assign bus.read_L1_L2  = granted & rd_q;
  assign bus.write_L1_L2 = granted & wr_q;
  assign bus.owner       = granted && (owner_q == OWN_D);
  assign bus.tag_L1_L2   = tag_q;
  assign bus.index_L1_L2 = index_q;
  assign bus.wdata_L1_L2 = wdata_q;
  assign bus.ready_L2_I  = ready_to_icache;
  assign bus.ready_L2_D  = ready_to_dcache;
  assign bus.arb_err     = timeout_hit;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb_l1_l2_arbiter: directed bench for l1_l2_arbiter with a scoreboard of expected grants.
// Build with L1_L2_ARB_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT=16).
module tb_l1_l2_arbiter;
  import l1_l2_arb_pkg::*;

  localparam int TNUM_2 = 18;
  localparam int INUM_2 = 8;
  localparam int BLK_W  = 512;

  typedef struct {
    logic              owner;
    logic              rd;
    logic              wr;
    logic [TNUM_2-1:0] tag;
    logic [INUM_2-1:0] index;
    logic [BLK_W-1:0]  wdata;
  } txn_t;

  logic clk = 1'b0;
  logic nrst;

  txn_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 clk = ~clk;

  l1_l2_arbiter_if #(.TNUM_2(TNUM_2), .INUM_2(INUM_2), .BLK_W(BLK_W)) bus ();

  l1_l2_arbiter #(
    .TNUM_2 (TNUM_2),
    .INUM_2 (INUM_2),
    .BLK_W  (BLK_W)
`ifdef L1_L2_ARB_TIMEOUT_EN
    ,
    .TIMEOUT(16)
`endif
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  function automatic txn_t mkTxn(input logic o, input logic r, input logic w,
                                 input logic [TNUM_2-1:0] t, input logic [INUM_2-1:0] i,
                                 input logic [BLK_W-1:0] d);
    txn_t x;
    x.owner = o; x.rd = r; x.wr = w; x.tag = t; x.index = i; x.wdata = d;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [BLK_W-1:0] observed,
                             input logic [BLK_W-1:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
  endtask

  task automatic applyStimulus(input logic rdI, input logic [TNUM_2-1:0] tagI,
                               input logic [INUM_2-1:0] idxI, input logic rdD, input logic wrD,
                               input logic [TNUM_2-1:0] tagD, input logic [INUM_2-1:0] idxD,
                               input logic [BLK_W-1:0] wdD);
    bus.read_I_L2  = rdI;
    bus.tag_I_L2   = tagI;
    bus.index_I_L2 = idxI;
    bus.read_D_L2  = rdD;
    bus.write_D_L2 = wrD;
    bus.tag_D_L2   = tagD;
    bus.index_D_L2 = idxD;
    bus.wdata_D_L2 = wdD;
  endtask

  task automatic waitGrant(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!(bus.read_L1_L2 || bus.write_L1_L2) && cycles < 20);
    checkOutput("grant_seen", bus.read_L1_L2 | bus.write_L1_L2, 1'b1);
  endtask

  task automatic checkGrant();
    txn_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("owner", bus.owner, e.owner);
      checkOutput("read_L1_L2", bus.read_L1_L2, e.rd);
      checkOutput("write_L1_L2", bus.write_L1_L2, e.wr);
      checkOutput("tag_L1_L2", bus.tag_L1_L2, e.tag);
      checkOutput("index_L1_L2", bus.index_L1_L2, e.index);
      checkOutput("wdata_L1_L2", bus.wdata_L1_L2, e.wdata);
    end
  endtask

  task automatic completeTxn(input logic expOwner, input logic dropI, input logic dropD);
    bus.ready_L2_L1 = 1'b1;
    if (dropI) bus.read_I_L2 = 1'b0;
    if (dropD) begin
      bus.read_D_L2  = 1'b0;
      bus.write_D_L2 = 1'b0;
    end
    #1;
    checkOutput("ready_L2_I", bus.ready_L2_I, expOwner == 1'b0);
    checkOutput("ready_L2_D", bus.ready_L2_D, expOwner == 1'b1);
    tick();
    bus.ready_L2_L1 = 1'b0;
    checkOutput("release_no_req", bus.read_L1_L2 | bus.write_L1_L2, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    int k;
    logic [BLK_W-1:0] a5Block;
    a5Block = {64{8'hA5}};

    // Reset
    nrst = 1'b1;
    bus.ready_L2_L1 = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    tick();
    checkOutput("rst_read", bus.read_L1_L2, 1'b0);
    checkOutput("rst_write", bus.write_L1_L2, 1'b0);
    checkOutput("rst_owner", bus.owner, 1'b0);
    checkOutput("rst_tag", bus.tag_L1_L2, '0);
    checkOutput("rst_arb_err", bus.arb_err, 1'b0);
    nrst = 1'b0;
    tick();

    // 1: I alone
    $display("[TB] test 1: I alone");
    applyStimulus(1'b1, 18'h0ABCD, 8'h3C, 1'b0, 1'b0, '0, '0, '0);
    expQ.push_back(mkTxn(1'b0, 1'b1, 1'b0, 18'h0ABCD, 8'h3C, '0));
    waitGrant(c);
    checkOutput("grant_latency", c, 1);
    checkGrant();
    completeTxn(1'b0, 1'b1, 1'b0);

    // 2: D write-back
    $display("[TB] test 2: D write-back");
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 18'h12345, 8'h81, a5Block);
    expQ.push_back(mkTxn(1'b1, 1'b0, 1'b1, 18'h12345, 8'h81, a5Block));
    waitGrant(c);
    checkGrant();
    completeTxn(1'b1, 1'b0, 1'b1);

    // 3: contention after reset alternates I, D, I, D
    $display("[TB] test 3: contention");
    nrst = 1'b1;
    tick();
    nrst = 1'b0;
    applyStimulus(1'b1, 18'h00111, 8'h11, 1'b1, 1'b0, 18'h00222, 8'h22, '0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) expQ.push_back(mkTxn(1'b0, 1'b1, 1'b0, 18'h00111, 8'h11, '0));
      else            expQ.push_back(mkTxn(1'b1, 1'b1, 1'b0, 18'h00222, 8'h22, '0));
    end
    for (int i = 0; i < 4; i++) begin
      waitGrant(c);
      checkOutput("contention_latency", c, 1);
      checkGrant();
      completeTxn(i[0], i == 3, i == 3);
    end

    // 4: stability of captured request
    $display("[TB] test 4: stability");
    applyStimulus(1'b1, 18'h2AAAA, 8'h55, 1'b0, 1'b0, '0, '0, '0);
    expQ.push_back(mkTxn(1'b0, 1'b1, 1'b0, 18'h2AAAA, 8'h55, '0));
    waitGrant(c);
    checkGrant();
    bus.tag_I_L2   = 18'h15555;
    bus.index_I_L2 = 8'hAA;
    tick();
    checkOutput("stable_tag", bus.tag_L1_L2, 18'h2AAAA);
    checkOutput("stable_index", bus.index_L1_L2, 8'h55);
    bus.read_I_L2 = 1'b0;
    tick();
    checkOutput("hold_read", bus.read_L1_L2, 1'b1);
    checkOutput("hold_arb_err", bus.arb_err, 1'b0);
    completeTxn(1'b0, 1'b0, 1'b0);

    // 5: stray ready in IDLE, then reset during GNT_D
    $display("[TB] test 5: stray ready and reset mid-grant");
    bus.ready_L2_L1 = 1'b1;
    #1;
    checkOutput("stray_ready_I", bus.ready_L2_I, 1'b0);
    checkOutput("stray_ready_D", bus.ready_L2_D, 1'b0);
    tick();
    bus.ready_L2_L1 = 1'b0;
    checkOutput("stray_no_req", bus.read_L1_L2 | bus.write_L1_L2, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 18'h3F0F0, 8'h0F, '0);
    expQ.push_back(mkTxn(1'b1, 1'b1, 1'b0, 18'h3F0F0, 8'h0F, '0));
    waitGrant(c);
    checkGrant();
    nrst = 1'b1;
    bus.read_D_L2 = 1'b0;
    tick();
    checkOutput("mid_rst_read", bus.read_L1_L2, 1'b0);
    checkOutput("mid_rst_write", bus.write_L1_L2, 1'b0);
    checkOutput("mid_rst_owner", bus.owner, 1'b0);
    checkOutput("mid_rst_tag", bus.tag_L1_L2, '0);
    checkOutput("mid_rst_index", bus.index_L1_L2, '0);
    nrst = 1'b0;
    tick();

`ifdef L1_L2_ARB_TIMEOUT_EN
    // 6: watchdog abandons an unanswered grant
    $display("[TB] test 6: timeout");
    applyStimulus(1'b1, 18'h01234, 8'h44, 1'b0, 1'b0, '0, '0, '0);
    expQ.push_back(mkTxn(1'b0, 1'b1, 1'b0, 18'h01234, 8'h44, '0));
    waitGrant(c);
    checkGrant();
    k = 1;
    while (!bus.arb_err && k < 40) begin
      tick();
      k++;
    end
    checkOutput("timeout_cycle", k, 16);
    checkOutput("timeout_no_ready_I", bus.ready_L2_I, 1'b0);
    bus.read_I_L2 = 1'b0;
    tick();
    checkOutput("timeout_req_drop", bus.read_L1_L2, 1'b0);
    checkOutput("timeout_err_pulse", bus.arb_err, 1'b0);
    tick();
`else
    k = 0;
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
